// File: rtl/mips_intr_ctrl.sv
// Memory-mapped interrupt controller for the MIPS MCU.
// Requests on irq_in are synchronised, latched into PEND (edge or level per
// channel), masked and prioritised (lowest index wins). One request at a time
// is presented to the MCU on intr. int_ack latches the vector, and an EOI
// write ends service.
//
// Bus handshake: a register access is a single-cycle strobe. io_cs&io_wr
// commits a write on the rising edge where both are high. io_cs&io_rd loads
// io_rdata on that edge, and io_rdata holds until the next read. There is
// no wait state and no backpressure.
module mips_intr_ctrl #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 3
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   irq_in,
    input  logic              io_cs,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [31:0]       io_wdata,
    output logic [31:0]       io_rdata,
    output logic              intr,
    input  logic              int_ack,
    output logic [4:0]        int_vec,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] A_PEND = 32'd0;
    localparam logic [31:0] A_MASK = 32'd1;
    localparam logic [31:0] A_MODE = 32'd2;
    localparam logic [31:0] A_STAT = 32'd3;
    localparam logic [31:0] A_EOI  = 32'd4;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0] synced;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] mask_q;
    logic [N_CH-1:0] mode_q;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] win_oh;
    logic [N_CH-1:0] edge_set;
    logic [N_CH-1:0] clr;
    logic [4:0]      win_idx;
    logic [4:0]      vec_q;
    logic            intr_q;
    logic [31:0]     io_rdata_q;
    logic [31:0]     rd_data;
    logic [31:0]     addr_ext;
    logic            wr_en, rd_en, eoi_wr, ack_take;
    state_t          state_q;
    logic            unused_wdata;

    // Data bits above the channel count have no register behind them.
    assign unused_wdata = ^io_wdata;

    assign addr_ext = 32'(io_addr);
    assign wr_en    = io_cs & io_wr;
    assign rd_en    = io_cs & io_rd;
    assign eoi_wr   = wr_en && (addr_ext == A_EOI) && (state_q == ST_SERVICE);
    assign synced   = sync_q[SYNC_STAGES-1];
    assign req      = pend_q & mask_q;
    assign win_oh   = req & (~req + N_CH'(1));
    assign ack_take = (state_q == ST_REQ) && int_ack && (|req);

    // Synchroniser chain plus the previous synced value for edge detection.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q <= synced;
        end
    end

    // Lowest-index active request selects the vector.
    always_comb begin
        win_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) win_idx = 5'(i);
        end
    end

    // Next PEND: edge channels set on a rising edge and clear by W1C or ack,
    // with set taking precedence. Level channels simply mirror the input.
    always_comb begin
        edge_set = synced & ~prev_q & mode_q;
        clr      = '0;
        if (wr_en && (addr_ext == A_PEND)) clr = clr | io_wdata[N_CH-1:0];
        if (ack_take)                      clr = clr | win_oh;
        pend_d = (mode_q & ((pend_q & ~clr) | edge_set)) | (~mode_q & synced);
    end

    // PEND, MASK and MODE registers.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_en && (addr_ext == A_MASK)) mask_q <= io_wdata[N_CH-1:0];
            if (wr_en && (addr_ext == A_MODE)) mode_q <= io_wdata[N_CH-1:0];
        end
    end

    // Read mux. Unmapped addresses and bits above N_CH read as zero.
    always_comb begin
        rd_data = '0;
        case (addr_ext)
            A_PEND: rd_data[N_CH-1:0] = pend_q;
            A_MASK: rd_data[N_CH-1:0] = mask_q;
            A_MODE: rd_data[N_CH-1:0] = mode_q;
            A_STAT: begin
                rd_data[31]  = (state_q == ST_SERVICE);
                rd_data[4:0] = vec_q;
            end
            default: rd_data = '0;
        endcase
    end

    // Registered read data, which holds between reads.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) io_rdata_q <= '0;
        else if (rd_en) io_rdata_q <= rd_data;
    end

    // Service FSM with registered intr and vector.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_REQ;
                        intr_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_take) begin
                        vec_q   <= win_idx;
                        state_q <= ST_SERVICE;
                        intr_q  <= 1'b0;
                    end else if (!(|req)) begin
                        state_q <= ST_IDLE;
                        intr_q  <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    intr_q <= 1'b0;
                    if (eoi_wr) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io_rdata  = io_rdata_q;
    assign intr      = intr_q;
    assign int_vec   = vec_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_intr_ctrl.sv
// Directed bench for mips_intr_ctrl: register access, edge and level
// requests, priority, withdraw, and asynchronous reset.
module tb_mips_intr_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        io_cs, io_rd, io_wr;
    logic [2:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        intr;
    logic        int_ack;
    logic [4:0]  int_vec;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    mips_intr_ctrl #(.N_CH(8), .SYNC_STAGES(2), .ADDR_W(3)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .io_cs    (io_cs),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .intr     (intr),
        .int_ack  (int_ack),
        .int_vec  (int_vec),
        .dbg_state(dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        io_cs = 1'b1; io_wr = 1'b1; io_addr = a; io_wdata = d;
        cyc(1);
        io_cs = 1'b0; io_wr = 1'b0; io_wdata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        io_cs = 1'b1; io_rd = 1'b1; io_addr = a;
        cyc(1);
        io_cs = 1'b0; io_rd = 1'b0;
        d = io_rdata;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
    endtask

    task automatic wait_intr(input logic exp, input int budget, input string name);
        for (int i = 0; i < budget && intr !== exp; i++) cyc(1);
        total++;
        if (intr !== exp) begin
            bad++;
            $display("FAIL %s: intr=%b expected %b (timeout)", name, intr, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL rst_intr: got %b exp 0", intr); end
        total++; if (int_vec !== 5'd0) begin bad++; $display("FAIL rst_vec: got %0d exp 0", int_vec); end
        total++; if (io_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h exp 0", io_rdata); end
        #7 reset = 1'b1;
        cyc(1);
        bus_read(3'd1, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_mask: got %h exp 0", d); end
        bus_read(3'd2, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_mode: got %h exp 0", d); end
        bus_read(3'd0, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_pend: got %h exp 0", d); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        bus_write(3'd2, 32'hFF);
        bus_write(3'd1, 32'h01);
        irq_in[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc(1);
            if (c == 1) irq_in[0] = 1'b0;
            total++;
            if (intr !== (c == 4)) begin
                bad++;
                $display("FAIL edge_latency c%0d: intr=%b exp %b", c, intr, (c == 4));
            end
        end
        do_ack();
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL edge_ack_intr: got %b exp 0", intr); end
        total++; if (int_vec !== 5'd0) begin bad++; $display("FAIL edge_ack_vec: got %0d exp 0", int_vec); end
        bus_read(3'd0, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL edge_pend: got %h exp 0", d); end
        bus_read(3'd3, d);
        total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL edge_stat: got %h exp 80000000", d); end
        bus_write(3'd4, 32'h0);
        bus_read(3'd3, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_eoi_stat: got %h exp 0", d); end
        cyc(2);
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL edge_idle_intr: got %b exp 0", intr); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        bus_write(3'd1, 32'hFF);
        irq_in = 8'h24;
        cyc(1);
        irq_in = 8'h00;
        wait_intr(1'b1, 8, "prio_intr");
        do_ack();
        total++; if (int_vec !== 5'd2) begin bad++; $display("FAIL prio_vec_first: got %0d exp 2", int_vec); end
        bus_read(3'd0, d);
        total++; if (d !== 32'h20) begin bad++; $display("FAIL prio_pend: got %h exp 20", d); end
        bus_write(3'd4, 32'h0);
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL prio_eoi_intr0: got %b exp 0", intr); end
        cyc(1);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL prio_reassert: got %b exp 1", intr); end
        do_ack();
        total++; if (int_vec !== 5'd5) begin bad++; $display("FAIL prio_vec_second: got %0d exp 5", int_vec); end
        bus_read(3'd0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL prio_pend_empty: got %h exp 0", d); end
        bus_write(3'd4, 32'h0);
        cyc(1);
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL prio_idle: got %b exp 0", intr); end
    endtask

    task automatic test_level();
        logic [31:0] d;
        bus_write(3'd2, 32'h00);
        bus_write(3'd1, 32'h08);
        irq_in[3] = 1'b1;
        wait_intr(1'b1, 8, "lvl_intr");
        do_ack();
        total++; if (int_vec !== 5'd3) begin bad++; $display("FAIL lvl_vec: got %0d exp 3", int_vec); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL lvl_ack_intr: got %b exp 0", intr); end
        bus_read(3'd0, d);
        total++; if (d !== 32'h08) begin bad++; $display("FAIL lvl_pend_held: got %h exp 08", d); end
        bus_write(3'd0, 32'h08);
        bus_read(3'd0, d);
        total++; if (d !== 32'h08) begin bad++; $display("FAIL lvl_w1c_noeffect: got %h exp 08", d); end
        bus_write(3'd4, 32'h0);
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL lvl_eoi_intr0: got %b exp 0", intr); end
        cyc(1);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL lvl_reassert: got %b exp 1", intr); end
        irq_in[3] = 1'b0;
        wait_intr(1'b0, 8, "lvl_drop");
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL lvl_state: got %0d exp 0", dbg_state); end
        bus_read(3'd3, d);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL lvl_stat: got %h exp 3", d); end
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        bus_write(3'd2, 32'hFF);
        bus_write(3'd1, 32'h02);
        irq_in[1] = 1'b1;
        cyc(1);
        irq_in[1] = 1'b0;
        wait_intr(1'b1, 8, "wd_intr");
        bus_write(3'd4, 32'h0);
        cyc(1);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL wd_eoi_ignored: got %b exp 1", intr); end
        bus_write(3'd0, 32'h02);
        cyc(1);
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL wd_drop: got %b exp 0", intr); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL wd_state: got %0d exp 0", dbg_state); end
        total++; if (int_vec !== 5'd3) begin bad++; $display("FAIL wd_vec_kept: got %0d exp 3", int_vec); end
        irq_in[1] = 1'b1;
        cyc(1);
        irq_in[1] = 1'b0;
        cyc(1);
        bus_write(3'd0, 32'h02);
        bus_read(3'd0, d);
        total++; if (d !== 32'h02) begin bad++; $display("FAIL wd_set_wins: got %h exp 02", d); end
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL wd_set_intr: got %b exp 1", intr); end
        do_ack();
        total++; if (int_vec !== 5'd1) begin bad++; $display("FAIL wd_vec: got %0d exp 1", int_vec); end
        bus_write(3'd4, 32'h0);
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus_read(3'd5, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_5: got %h exp 0", d); end
        bus_read(3'd7, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_7: got %h exp 0", d); end
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read(3'd1, d);
        total++; if (d !== 32'hFF) begin bad++; $display("FAIL mask_width: got %h exp ff", d); end
        cyc(3);
        total++; if (io_rdata !== 32'hFF) begin bad++; $display("FAIL rdata_hold: got %h exp ff", io_rdata); end
        do_ack();
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL ack_idle_state: got %0d exp 0", dbg_state); end
        total++; if (int_vec !== 5'd1) begin bad++; $display("FAIL ack_idle_vec: got %0d exp 1", int_vec); end
        bus_write(3'd1, 32'h0);
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        bus_write(3'd1, 32'h10);
        irq_in[4] = 1'b1;
        cyc(1);
        irq_in[4] = 1'b0;
        wait_intr(1'b1, 8, "ar_intr");
        do_ack();
        total++; if (int_vec !== 5'd4) begin bad++; $display("FAIL ar_vec: got %0d exp 4", int_vec); end
        bus_read(3'd3, d);
        total++; if (d !== 32'h8000_0004) begin bad++; $display("FAIL ar_stat: got %h exp 80000004", d); end
        #3 reset = 1'b0;
        #1;
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL ar_intr0: got %b exp 0", intr); end
        total++; if (int_vec !== 5'd0) begin bad++; $display("FAIL ar_vec0: got %0d exp 0", int_vec); end
        total++; if (io_rdata !== 32'h0) begin bad++; $display("FAIL ar_rdata0: got %h exp 0", io_rdata); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL ar_state0: got %0d exp 0", dbg_state); end
        #3 reset = 1'b1;
        cyc(1);
        bus_read(3'd1, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ar_mask: got %h exp 0", d); end
        bus_read(3'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ar_mode: got %h exp 0", d); end
    endtask

    initial begin
        reset    = 1'b0;
        irq_in   = '0;
        io_cs    = 1'b0;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        io_addr  = '0;
        io_wdata = '0;
        int_ack  = 1'b0;
        #15;
        test_reset();
        test_edge();
        test_priority();
        test_level();
        test_withdraw();
        test_unmapped();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
